// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN error manager: FSM state encoding,
// Error_state values and the fault-confinement constants.
// ---------------------------------------------------------------------------
package can_pkg;

    // Error-handling FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLAG       = 3'd1,
        ST_WAIT_DELIM = 3'd2,
        ST_DELIM      = 3'd3,
        ST_BUS_OFF    = 3'd4
    } can_state_e;

    // Error_state output values
    localparam logic [1:0] ES_ACTIVE  = 2'd0;
    localparam logic [1:0] ES_PASSIVE = 2'd1;
    localparam logic [1:0] ES_BUS_OFF = 2'd2;

    // Bus-off recovery: RECOVERY_SEQS runs of RECOVERY_RUN recessive samples
    localparam int RECOVERY_SEQS = 128;
    localparam int RECOVERY_RUN  = 11;

    // Counter limits
    localparam int COUNT_LIMIT   = 255;  // REC saturation, TEC bus-off threshold
    localparam int TEC_BUS_OFF   = 256;  // TEC held here while bus off
    localparam int PASSIVE_LIMIT = 127;  // above this a counter is error passive
    localparam int TEC_STEP      = 8;
    localparam int REC_RELOAD    = 120;

    // Confinement state from the registered counters
    function automatic logic [1:0] classify_state(input logic [8:0] tec,
                                                  input logic [7:0] rec);
        if (tec > 9'(COUNT_LIMIT))
            return ES_BUS_OFF;
        else if (tec > 9'(PASSIVE_LIMIT) || rec > 8'(PASSIVE_LIMIT))
            return ES_PASSIVE;
        else
            return ES_ACTIVE;
    endfunction

endpackage

// File: rtl/can_fault_counters.sv
// ---------------------------------------------------------------------------
// can_fault_counters
// Transmit/receive error counters and the derived confinement state.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   form_i..ack_i       error-monitor flags (ack only counts when transmitting)
//   transmitter_i       1 = this node is transmitting
//   event_en_i          monitor flags are only honoured while this is high
//   frame_ok_i          successful-frame pulse (already gated by the FSM)
//   recover_i           one-cycle pulse at bus-off recovery, clears both counters
//   error_event_o       qualified error event (drives the FSM)
//   bus_off_o           TEC above the bus-off threshold
//   tec_o, rec_o        registered counters
//   error_state_o       0 active, 1 passive, 2 bus off
// ---------------------------------------------------------------------------
module can_fault_counters
    import can_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       form_i,
    input  logic       bit_i,
    input  logic       stuff_i,
    input  logic       crc_i,
    input  logic       ack_i,
    input  logic       transmitter_i,
    input  logic       event_en_i,
    input  logic       frame_ok_i,
    input  logic       recover_i,
    output logic       error_event_o,
    output logic       bus_off_o,
    output logic [8:0] tec_o,
    output logic [7:0] rec_o,
    output logic [1:0] error_state_o
);

    logic [8:0] tec_q, tec_d;
    logic [7:0] rec_q, rec_d;
    logic       raw_event;

    // Simultaneous flags collapse into a single event
    assign raw_event     = form_i | bit_i | stuff_i | crc_i | (ack_i & transmitter_i);
    assign bus_off_o     = (tec_q > 9'(COUNT_LIMIT));
    // Once TEC has crossed the threshold the counters are frozen until recovery
    assign error_event_o = raw_event & event_en_i & ~bus_off_o;

    always_comb begin
        tec_d = tec_q;
        rec_d = rec_q;
        if (recover_i) begin
            tec_d = '0;
            rec_d = '0;
        end else if (!bus_off_o) begin
            if (error_event_o) begin
                if (transmitter_i) begin
                    if (tec_q >= 9'(TEC_BUS_OFF - TEC_STEP))
                        tec_d = 9'(TEC_BUS_OFF);
                    else
                        tec_d = tec_q + 9'(TEC_STEP);
                end else if (rec_q != 8'(COUNT_LIMIT)) begin
                    rec_d = rec_q + 8'd1;
                end
            end else if (frame_ok_i) begin
                // Error wins over Frame_ok: this branch is only reached without an event
                if (transmitter_i) begin
                    if (tec_q != '0)
                        tec_d = tec_q - 9'd1;
                end else if (rec_q > 8'(PASSIVE_LIMIT)) begin
                    rec_d = 8'(REC_RELOAD);
                end else if (rec_q != '0) begin
                    rec_d = rec_q - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tec_q <= '0;
            rec_q <= '0;
        end else begin
            tec_q <= tec_d;
            rec_q <= rec_d;
        end
    end

    assign tec_o         = tec_q;
    assign rec_o         = rec_q;
    assign error_state_o = classify_state(tec_q, rec_q);

endmodule

// File: rtl/can_error_manager.sv
// ---------------------------------------------------------------------------
// can_error_manager
// CAN error-frame sequencer and fault confinement. Counts bus errors,
// drives the error flag / delimiter and handles bus-off recovery.
//
// Ports
//   Clock_TB, Reset          clock, asynchronous active-high reset
//   Bit_Sample               one-cycle strobe at each bit sample point
//   Bit_Entrada              sampled bus level (1 = recessive)
//   Transmitter              1 = this node transmits the current frame
//   Form/Bit/Stuff/CRC/Ack_monitor  error-monitor flags
//   Frame_ok                 frame completed without error
//   Bit_Saida                bus drive level (1 = recessive)
//   Error_frame_active       high in FLAG, WAIT_DELIM and DELIM
//   TEC, REC                 error counters
//   Error_state              0 active, 1 passive, 2 bus off
// ---------------------------------------------------------------------------
module can_error_manager
    import can_pkg::*;
#(
    parameter int FLAG_BITS  = 6,
    parameter int DELIM_BITS = 8
) (
    input  logic       Clock_TB,
    input  logic       Reset,
    input  logic       Bit_Sample,
    input  logic       Bit_Entrada,
    input  logic       Transmitter,
    input  logic       Form_monitor,
    input  logic       Bit_monitor,
    input  logic       Stuff_monitor,
    input  logic       CRC_monitor,
    input  logic       Ack_monitor,
    input  logic       Frame_ok,
    output logic       Bit_Saida,
    output logic       Error_frame_active,
    output logic [8:0] TEC,
    output logic [7:0] REC,
    output logic [1:0] Error_state
);

    localparam int MAX_BITS = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    can_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic [6:0]       seq_cnt_q, seq_cnt_d;
    logic             recover;
    logic             error_event;
    logic             bus_off;
    logic [1:0]       error_state;

    can_fault_counters u_counters (
        .clk_i         (Clock_TB),
        .rst_i         (Reset),
        .form_i        (Form_monitor),
        .bit_i         (Bit_monitor),
        .stuff_i       (Stuff_monitor),
        .crc_i         (CRC_monitor),
        .ack_i         (Ack_monitor),
        .transmitter_i (Transmitter),
        .event_en_i    (state_q == ST_IDLE),
        .frame_ok_i    (Frame_ok && (state_q != ST_BUS_OFF)),
        .recover_i     (recover),
        .error_event_o (error_event),
        .bus_off_o     (bus_off),
        .tec_o         (TEC),
        .rec_o         (REC),
        .error_state_o (error_state)
    );

    always_ff @(posedge Clock_TB or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            run_cnt_q <= '0;
            seq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            run_cnt_q <= run_cnt_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        run_cnt_d = run_cnt_q;
        seq_cnt_d = seq_cnt_q;
        recover   = 1'b0;

        // Crossing the TEC threshold overrides whatever the frame was doing
        if (state_q != ST_BUS_OFF && bus_off) begin
            state_d   = ST_BUS_OFF;
            bit_cnt_d = '0;
            run_cnt_d = '0;
            seq_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (error_event) begin
                        state_d   = ST_FLAG;
                        bit_cnt_d = '0;
                    end
                end
                ST_FLAG: begin
                    if (Bit_Sample) begin
                        if (bit_cnt_q == CNT_W'(FLAG_BITS - 1)) begin
                            state_d   = ST_WAIT_DELIM;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_DELIM: begin
                    // The first recessive sample is already delimiter bit 1
                    if (Bit_Sample && Bit_Entrada) begin
                        if (DELIM_BITS <= 1) begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = ST_DELIM;
                            bit_cnt_d = CNT_W'(1);
                        end
                    end
                end
                ST_DELIM: begin
                    if (Bit_Sample) begin
                        if (!Bit_Entrada) begin
                            state_d   = ST_FLAG;
                            bit_cnt_d = '0;
                        end else if (bit_cnt_q == CNT_W'(DELIM_BITS - 1)) begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_BUS_OFF: begin
                    if (Bit_Sample) begin
                        // A dominant bit only restarts the current run, not the sequence count
                        if (!Bit_Entrada) begin
                            run_cnt_d = '0;
                        end else if (run_cnt_q == 4'(RECOVERY_RUN - 1)) begin
                            run_cnt_d = '0;
                            if (seq_cnt_q == 7'(RECOVERY_SEQS - 1)) begin
                                seq_cnt_d = '0;
                                recover   = 1'b1;
                                state_d   = ST_IDLE;
                            end else begin
                                seq_cnt_d = seq_cnt_q + 7'd1;
                            end
                        end else begin
                            run_cnt_d = run_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Error-passive nodes send a recessive (passive) flag
    assign Bit_Saida          = ~((state_q == ST_FLAG) && (error_state == ES_ACTIVE));
    assign Error_frame_active = (state_q == ST_FLAG) || (state_q == ST_WAIT_DELIM) ||
                                (state_q == ST_DELIM);
    assign Error_state        = error_state;

endmodule

// File: tb/tb_can_error_manager.sv
module tb_can_error_manager;

    localparam int FLAG_BITS  = 6;
    localparam int DELIM_BITS = 8;

    logic       Clock_TB = 1'b0;
    logic       Reset = 1'b1;
    logic       Bit_Sample = 1'b0;
    logic       Bit_Entrada = 1'b1;
    logic       Transmitter = 1'b0;
    logic       Form_monitor = 1'b0;
    logic       Bit_monitor = 1'b0;
    logic       Stuff_monitor = 1'b0;
    logic       CRC_monitor = 1'b0;
    logic       Ack_monitor = 1'b0;
    logic       Frame_ok = 1'b0;
    logic       Bit_Saida;
    logic       Error_frame_active;
    logic [8:0] TEC;
    logic [7:0] REC;
    logic [1:0] Error_state;

    can_error_manager #(.FLAG_BITS(FLAG_BITS), .DELIM_BITS(DELIM_BITS)) dut (
        .Clock_TB           (Clock_TB),
        .Reset              (Reset),
        .Bit_Sample         (Bit_Sample),
        .Bit_Entrada        (Bit_Entrada),
        .Transmitter        (Transmitter),
        .Form_monitor       (Form_monitor),
        .Bit_monitor        (Bit_monitor),
        .Stuff_monitor      (Stuff_monitor),
        .CRC_monitor        (CRC_monitor),
        .Ack_monitor        (Ack_monitor),
        .Frame_ok           (Frame_ok),
        .Bit_Saida          (Bit_Saida),
        .Error_frame_active (Error_frame_active),
        .TEC                (TEC),
        .REC                (REC),
        .Error_state        (Error_state)
    );

    always #5 Clock_TB = ~Clock_TB;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int bs;
        int efa;
        int tec;
        int rec;
        int es;
    } exp_t;

    exp_t exp_q[$];

    function automatic void cmp(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: node behaviour described as a mode plus counts
    // ------------------------------------------------------------------
    localparam int MD_NORMAL = 0;
    localparam int MD_FLAG   = 1;
    localparam int MD_GAP    = 2;
    localparam int MD_DELIM  = 3;
    localparam int MD_OFF    = 4;

    int m_tec, m_rec, m_mode, m_flag_seen, m_delim_seen, m_run, m_seqs;

    function automatic int es_of(input int t, input int r);
        if (t > 255) return 2;
        if (t > 127 || r > 127) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m_tec = 0; m_rec = 0; m_mode = MD_NORMAL;
        m_flag_seen = 0; m_delim_seen = 0; m_run = 0; m_seqs = 0;
    endfunction

    function automatic void model_step(input logic smp, input logic ent, input logic tx,
                                       input logic [4:0] mon, input logic fok);
        int nt, nr, nm;
        bit ev, counted;
        nt = m_tec; nr = m_rec; nm = m_mode;
        ev = (mon[4:1] != 4'b0) || (mon[0] && tx);
        counted = (m_mode == MD_NORMAL) && (m_tec <= 255) && ev;
        if (m_tec <= 255 && m_mode != MD_OFF) begin
            if (counted) begin
                if (tx) nt = (m_tec + 8 > 256) ? 256 : m_tec + 8;
                else    nr = (m_rec + 1 > 255) ? 255 : m_rec + 1;
            end else if (fok) begin
                if (tx) begin
                    if (m_tec > 0) nt = m_tec - 1;
                end else if (m_rec > 127) nr = 120;
                else if (m_rec > 0) nr = m_rec - 1;
            end
        end
        if (m_mode != MD_OFF && m_tec > 255) begin
            nm = MD_OFF; m_run = 0; m_seqs = 0;
        end else begin
            case (m_mode)
                MD_NORMAL: if (counted) begin nm = MD_FLAG; m_flag_seen = 0; end
                MD_FLAG: if (smp) begin
                    m_flag_seen++;
                    if (m_flag_seen == FLAG_BITS) nm = MD_GAP;
                end
                MD_GAP: if (smp && ent) begin
                    m_delim_seen = 1;
                    nm = (m_delim_seen >= DELIM_BITS) ? MD_NORMAL : MD_DELIM;
                end
                MD_DELIM: if (smp) begin
                    if (!ent) begin nm = MD_FLAG; m_flag_seen = 0; end
                    else begin
                        m_delim_seen++;
                        if (m_delim_seen == DELIM_BITS) nm = MD_NORMAL;
                    end
                end
                default: if (smp) begin
                    if (!ent) m_run = 0;
                    else begin
                        m_run++;
                        if (m_run == 11) begin
                            m_run = 0;
                            m_seqs++;
                            if (m_seqs == 128) begin
                                m_seqs = 0; nm = MD_NORMAL; nt = 0; nr = 0;
                            end
                        end
                    end
                end
            endcase
        end
        m_tec = nt; m_rec = nr; m_mode = nm;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.tec = m_tec;
        e.rec = m_rec;
        e.es  = es_of(m_tec, m_rec);
        e.efa = (m_mode == MD_FLAG || m_mode == MD_GAP || m_mode == MD_DELIM) ? 1 : 0;
        e.bs  = (m_mode == MD_FLAG && e.es == 0) ? 0 : 1;
        exp_q.push_back(e);
    endfunction

    // Monitor: DUT presents a new output set every clock
    always @(negedge Clock_TB) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("bit_saida", int'(Bit_Saida), e.bs);
            cmp("error_frame_active", int'(Error_frame_active), e.efa);
            cmp("tec", int'(TEC), e.tec);
            cmp("rec", int'(REC), e.rec);
            cmp("error_state", int'(Error_state), e.es);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic smp, input logic ent, input logic tx,
                       input logic [4:0] mon, input logic fok);
        Bit_Sample    = smp;
        Bit_Entrada   = ent;
        Transmitter   = tx;
        Form_monitor  = mon[4];
        Bit_monitor   = mon[3];
        Stuff_monitor = mon[2];
        CRC_monitor   = mon[1];
        Ack_monitor   = mon[0];
        Frame_ok      = fok;
        @(posedge Clock_TB);
        #1;
        model_step(smp, ent, tx, mon, fok);
        push_exp();
        Bit_Sample = 1'b0;
        {Form_monitor, Bit_monitor, Stuff_monitor, CRC_monitor, Ack_monitor} = 5'b0;
        Frame_ok = 1'b0;
    endtask

    task automatic err_frame(input logic tx, input logic [4:0] mon);
        cyc(1'b0, 1'b1, tx, mon, 1'b0);
        repeat (FLAG_BITS) cyc(1'b1, 1'b0, tx, 5'b0, 1'b0);
        repeat (DELIM_BITS) cyc(1'b1, 1'b1, tx, 5'b0, 1'b0);
    endtask

    task automatic do_reset();
        #5;
        Reset = 1'b1;
        #1;
        cmp("rst_bit_saida", int'(Bit_Saida), 1);
        cmp("rst_efa", int'(Error_frame_active), 0);
        cmp("rst_tec", int'(TEC), 0);
        model_reset();
        repeat (2) begin
            Bit_Sample  = 1'($urandom_range(0, 1));
            Bit_Entrada = 1'($urandom_range(0, 1));
            @(posedge Clock_TB);
            #1;
            push_exp();
        end
        Bit_Sample  = 1'b0;
        Bit_Entrada = 1'b1;
        Reset = 1'b0;
    endtask

    task automatic to_bus_off();
        do_reset();
        repeat (31) err_frame(1'b1, 5'b01000);
        cmp("tec_248", int'(TEC), 248);
        cyc(1'b0, 1'b1, 1'b1, 5'b01000, 1'b0);
        cmp("tec_256", int'(TEC), 256);
        cmp("es_bus_off", int'(Error_state), 2);
        cyc(1'b0, 1'b1, 1'b1, 5'b0, 1'b1);
        cmp("bus_off_efa", int'(Error_frame_active), 0);
        cmp("bus_off_bit_saida", int'(Bit_Saida), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) begin
            @(posedge Clock_TB);
            #1;
            push_exp();
        end
        Reset = 1'b0;

        // Receive error, flag driven dominant, full delimiter
        cyc(1'b0, 1'b1, 1'b0, 5'b10000, 1'b0);
        cmp("rx_rec_1", int'(REC), 1);
        cmp("rx_flag_dominant", int'(Bit_Saida), 0);
        repeat (FLAG_BITS) cyc(1'b1, 1'b0, 1'b0, 5'b0, 1'b0);
        cmp("rx_wait_delim_bs", int'(Bit_Saida), 1);
        cmp("rx_wait_delim_efa", int'(Error_frame_active), 1);
        repeat (DELIM_BITS - 1) cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("rx_delim_not_done", int'(Error_frame_active), 1);
        cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("rx_back_idle", int'(Error_frame_active), 0);

        // Two flags in one cycle count once; then reach error passive
        do_reset();
        err_frame(1'b1, 5'b01100);
        cmp("tx_tec_8", int'(TEC), 8);
        repeat (15) err_frame(1'b1, 5'b00001);
        cmp("tx_tec_128", int'(TEC), 128);
        cmp("tx_passive", int'(Error_state), 1);
        cyc(1'b0, 1'b1, 1'b1, 5'b01000, 1'b0);
        cmp("passive_flag_efa", int'(Error_frame_active), 1);
        cmp("passive_flag_recessive", int'(Bit_Saida), 1);
        repeat (FLAG_BITS) cyc(1'b1, 1'b0, 1'b1, 5'b0, 1'b0);
        repeat (DELIM_BITS) cyc(1'b1, 1'b1, 1'b1, 5'b0, 1'b0);

        // Ack ignored while receiving
        cyc(1'b0, 1'b1, 1'b0, 5'b00001, 1'b0);
        cmp("rx_ack_ignored", int'(Error_frame_active), 0);

        // Bus off and plain recovery
        to_bus_off();
        repeat (1407) cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("recov_not_yet", int'(Error_state), 2);
        cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("recov_es", int'(Error_state), 0);
        cmp("recov_tec", int'(TEC), 0);

        // Dominant sample as 10th bit of a run
        to_bus_off();
        repeat (9) cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'b0, 1'b0);
        repeat (1407) cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("recov_delay_early", int'(Error_state), 2);
        cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);
        cmp("recov_delay_es", int'(Error_state), 0);

        // REC above 127 reloads to 120; error beats Frame_ok
        do_reset();
        repeat (130) err_frame(1'b0, 5'b10000);
        cmp("rec_130", int'(REC), 130);
        cyc(1'b0, 1'b1, 1'b0, 5'b0, 1'b1);
        cmp("rec_reload_120", int'(REC), 120);
        cyc(1'b0, 1'b1, 1'b0, 5'b00010, 1'b1);
        cmp("rec_error_wins", int'(REC), 121);
        repeat (FLAG_BITS) cyc(1'b1, 1'b0, 1'b0, 5'b0, 1'b0);
        repeat (DELIM_BITS) cyc(1'b1, 1'b1, 1'b0, 5'b0, 1'b0);

        // Reset in the middle of an error frame
        cyc(1'b0, 1'b1, 1'b1, 5'b00100, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 5'b0, 1'b0);
        do_reset();

        // Randomized traffic, error-heavy phase then lighter phase
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] mon;
            int rate;
            rate = (i < 2000) ? 8 : 40;
            for (int b = 0; b < 5; b++)
                mon[b] = ($urandom_range(0, rate - 1) == 0);
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                (i < 2000) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)),
                mon, ($urandom_range(0, 15) == 0));
        end

        repeat (2) @(posedge Clock_TB);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
